// File: rtl/axi4s_upsizer_pkg.sv
// Shared types and sizing for the AXI4-Stream 8-byte to 32-byte upsizer.
// Output width is IN_BYTES*RATIO bytes; tuser carries one 4-bit field per lane.
package axi4sDemo;

   localparam int IN_BYTES  = 8;
   localparam int RATIO     = 4;
   localparam int OUT_BYTES = IN_BYTES * RATIO;
   localparam int USER_W    = 4;
   localparam int LANE_W    = $clog2(RATIO);

   typedef logic [IN_BYTES*8-1:0]   data_t1_t;
   typedef logic [OUT_BYTES*8-1:0]  data_t2_t;
   typedef logic [IN_BYTES-1:0]     keep_t1_t;
   typedef logic [OUT_BYTES-1:0]    keep_t2_t;
   typedef logic [3:0]              tid_t1_t;
   typedef logic [3:0]              tid_t2_t;
   typedef logic [3:0]              tdest_t1_t;
   typedef logic [3:0]              tdest_t2_t;
   typedef logic [USER_W-1:0]       tuser_t1_t;
   typedef logic [USER_W*RATIO-1:0] tuser_t2_t;
   typedef logic [LANE_W-1:0]       lane_t;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/axi4s_upsizer_pack.sv
// Lane counter and packed-word registers of the upsizer; the top decides when to
// write a beat, clear the word and rewind the lane counter.
module axi4s_upsizer_pack
   import axi4sDemo::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      i_wr,
   input  logic      i_clr,
   input  logic      i_lane_zero,
   input  data_t1_t  i_tdata,
   input  keep_t1_t  i_tstrb,
   input  keep_t1_t  i_tkeep,
   input  tid_t1_t   i_tid,
   input  tdest_t1_t i_tdest,
   input  tuser_t1_t i_tuser,
   input  logic      i_tlast,
   output lane_t     o_lane,
   output data_t2_t  o_tdata,
   output keep_t2_t  o_tstrb,
   output keep_t2_t  o_tkeep,
   output tid_t2_t   o_tid,
   output tdest_t2_t o_tdest,
   output tuser_t2_t o_tuser,
   output logic      o_tlast
);

   lane_t     r_lane,  w_lane_n, w_wl;
   data_t2_t  r_tdata, w_tdata_n;
   keep_t2_t  r_tstrb, w_tstrb_n;
   keep_t2_t  r_tkeep, w_tkeep_n;
   tid_t2_t   r_tid,   w_tid_n;
   tdest_t2_t r_tdest, w_tdest_n;
   tuser_t2_t r_tuser, w_tuser_n;
   logic      r_tlast, w_tlast_n;

   // A clear combined with a write starts a fresh word with the beat in lane 0.
   always_comb begin
      w_wl      = i_clr ? '0 : r_lane;
      w_tdata_n = i_clr ? '0 : r_tdata;
      w_tstrb_n = i_clr ? '0 : r_tstrb;
      w_tkeep_n = i_clr ? '0 : r_tkeep;
      w_tuser_n = i_clr ? '0 : r_tuser;
      w_tid_n   = i_clr ? '0 : r_tid;
      w_tdest_n = i_clr ? '0 : r_tdest;
      w_tlast_n = i_clr ? 1'b0 : r_tlast;
      if (i_wr) begin
         for (int k = 0; k < RATIO; k++) begin
            if (w_wl == lane_t'(k)) begin
               w_tdata_n[k*IN_BYTES*8 +: IN_BYTES*8] = i_tdata;
               w_tstrb_n[k*IN_BYTES +: IN_BYTES]     = i_tstrb;
               w_tkeep_n[k*IN_BYTES +: IN_BYTES]     = i_tkeep;
               w_tuser_n[k*USER_W +: USER_W]         = i_tuser;
            end
         end
         if (w_wl == '0) begin
            w_tid_n   = i_tid;
            w_tdest_n = i_tdest;
         end
         w_tlast_n = i_tlast;
      end
      w_lane_n = i_lane_zero ? '0 : (i_wr ? w_wl + lane_t'(1) : w_wl);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lane  <= '0;
         r_tdata <= '0;
         r_tstrb <= '0;
         r_tkeep <= '0;
         r_tid   <= '0;
         r_tdest <= '0;
         r_tuser <= '0;
         r_tlast <= 1'b0;
      end else begin
         r_lane  <= w_lane_n;
         r_tdata <= w_tdata_n;
         r_tstrb <= w_tstrb_n;
         r_tkeep <= w_tkeep_n;
         r_tid   <= w_tid_n;
         r_tdest <= w_tdest_n;
         r_tuser <= w_tuser_n;
         r_tlast <= w_tlast_n;
      end
   end

   assign o_lane  = r_lane;
   assign o_tdata = r_tdata;
   assign o_tstrb = r_tstrb;
   assign o_tkeep = r_tkeep;
   assign o_tid   = r_tid;
   assign o_tdest = r_tdest;
   assign o_tuser = r_tuser;
   assign o_tlast = r_tlast;

endmodule

// File: rtl/axi4s_upsizer.sv
// AXI4-Stream upsizer: packs RATIO 8-byte beats into one 32-byte word (ACC/HOLD FSM).
// Define AXI4S_UPSIZER_ID_FLUSH_EN to flush a partial word when tid/tdest change.
// Handshake: a transfer happens on a rising edge where tvalid and tready are both 1;
// out_tvalid is held with stable payload until out_tready, and in_tready never
// depends on in_tvalid except through the optional ID flush.
module axi4s_upsizer
   import axi4sDemo::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        axis4_in_tvalid,
   output logic        axis4_in_tready,
   input  logic        axis4_in_tlast,
   input  data_t1_t    axis4_in_tdata,
   input  keep_t1_t    axis4_in_tstrb,
   input  keep_t1_t    axis4_in_tkeep,
   input  tid_t1_t     axis4_in_tid,
   input  tdest_t1_t   axis4_in_tdest,
   input  tuser_t1_t   axis4_in_tuser,
   output logic        axis4_out_tvalid,
   input  logic        axis4_out_tready,
   output logic        axis4_out_tlast,
   output data_t2_t    axis4_out_tdata,
   output keep_t2_t    axis4_out_tstrb,
   output keep_t2_t    axis4_out_tkeep,
   output tid_t2_t     axis4_out_tid,
   output tdest_t2_t   axis4_out_tdest,
   output tuser_t2_t   axis4_out_tuser,
   output logic [15:0] pkt_count,
   output state_t      o_state
);

   localparam lane_t LAST_LANE = lane_t'(RATIO - 1);

   state_t      r_state, w_state_n;
   logic        w_ready, w_wr, w_clr, w_lane_zero, w_flush;
   lane_t       w_lane;
   logic [15:0] r_pkt_count;

`ifdef AXI4S_UPSIZER_ID_FLUSH_EN
   assign w_flush = axis4_in_tvalid && (r_state == ST_ACC) && (w_lane != '0) &&
                    ((axis4_in_tid != axis4_out_tid) || (axis4_in_tdest != axis4_out_tdest));
`else
   assign w_flush = 1'b0;
`endif

   always_comb begin
      w_state_n   = r_state;
      w_ready     = 1'b0;
      w_wr        = 1'b0;
      w_clr       = 1'b0;
      w_lane_zero = 1'b0;
      case (r_state)
         ST_ACC: begin
            if (w_flush) begin
               w_state_n   = ST_HOLD;
               w_lane_zero = 1'b1;
            end else begin
               w_ready = 1'b1;
               if (axis4_in_tvalid) begin
                  w_wr = 1'b1;
                  if (axis4_in_tlast || (w_lane == LAST_LANE)) begin
                     w_state_n   = ST_HOLD;
                     w_lane_zero = 1'b1;
                  end
               end
            end
         end
         ST_HOLD: begin
            w_ready = axis4_out_tready;
            if (axis4_out_tready) begin
               w_clr     = 1'b1;
               w_state_n = ST_ACC;
               // Overlapping accept keeps one beat per cycle across word boundaries.
               if (axis4_in_tvalid) begin
                  w_wr = 1'b1;
                  if (axis4_in_tlast) begin
                     w_state_n   = ST_HOLD;
                     w_lane_zero = 1'b1;
                  end
               end
            end
         end
         default: w_state_n = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_ACC;
         r_pkt_count <= '0;
      end else begin
         r_state <= w_state_n;
         if (axis4_out_tvalid && axis4_out_tready && axis4_out_tlast)
            r_pkt_count <= r_pkt_count + 16'd1;
      end
   end

   axi4s_upsizer_pack u_pack (
      .clk         (clk),
      .rst         (rst),
      .i_wr        (w_wr),
      .i_clr       (w_clr),
      .i_lane_zero (w_lane_zero),
      .i_tdata     (axis4_in_tdata),
      .i_tstrb     (axis4_in_tstrb),
      .i_tkeep     (axis4_in_tkeep),
      .i_tid       (axis4_in_tid),
      .i_tdest     (axis4_in_tdest),
      .i_tuser     (axis4_in_tuser),
      .i_tlast     (axis4_in_tlast),
      .o_lane      (w_lane),
      .o_tdata     (axis4_out_tdata),
      .o_tstrb     (axis4_out_tstrb),
      .o_tkeep     (axis4_out_tkeep),
      .o_tid       (axis4_out_tid),
      .o_tdest     (axis4_out_tdest),
      .o_tuser     (axis4_out_tuser),
      .o_tlast     (axis4_out_tlast)
   );

   assign axis4_in_tready  = w_ready & ~rst;
   assign axis4_out_tvalid = (r_state == ST_HOLD);
   assign pkt_count        = r_pkt_count;
   assign o_state          = r_state;

endmodule

// File: doc/axi4s_upsizer.md
AXI4S_UPSIZER -- requirements
Module: axi4s_upsizer

Interface
REQ-001 Parameter IN_BYTES, 8, input tdata width in bytes, SHALL be fixed at 8 for this release.
REQ-002 Parameter RATIO, 4, input beats per output beat; output width SHALL be IN_BYTES*RATIO bytes.
REQ-003 clk  in  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 axis4_in_tvalid/tready/tlast  in/out/in  1 each  AXI4-Stream sink handshake and packet end.
REQ-006 axis4_in_tdata/tstrb/tkeep  in  64/8/8  input beat payload, byte strobes, byte keeps.
REQ-007 axis4_in_tid/tdest/tuser  in  4/4/4  input side-band fields.
REQ-008 axis4_out_tvalid/tready/tlast  out/in/out  1 each  AXI4-Stream source handshake and packet end.
REQ-009 axis4_out_tdata/tstrb/tkeep  out  256/32/32  packed word, strobes, keeps.
REQ-010 axis4_out_tid/tdest/tuser  out  4/4/16  side-band; tuser is 4 lanes of 4 bits.
REQ-011 pkt_count  out  16  count of output beats with tlast=1, wrapping.

Function
REQ-012 Input beat k of a word (lane counter k=0..3) SHALL land in tdata[64k+:64], tstrb/tkeep[8k+:8], tuser[4k+:4].
REQ-013 States: ACC (out_tvalid=0, collecting) and HOLD (out_tvalid=1, word presented).
REQ-014 ACC->HOLD on an accepted beat with lane=3, or with tlast=1; out_tvalid SHALL rise the cycle after that acceptance (latency 1).
REQ-015 In HOLD, axis4_in_tready SHALL equal axis4_out_tready; in ACC, axis4_in_tready SHALL be 1 unless REQ-020 applies.
REQ-016 On an output handshake with a simultaneous input acceptance, the new beat SHALL be written to lane 0 of a cleared word; sustained throughput SHALL be 1 input beat/cycle.
REQ-017 On an output handshake without input acceptance: state->ACC, lane->0, word cleared.
REQ-018 Unfilled lanes of a partial word SHALL carry tdata, tstrb, tkeep, and tuser equal to zero.
REQ-019 out_tid/out_tdest SHALL be those of the lane-0 beat; out_tlast SHALL equal the tlast of the last written beat.
REQ-020 Per Configuration, an ID change in ACC with lane>0 SHALL force ACC->HOLD with in_tready=0 that cycle; the beat is not consumed.
REQ-021 All output payload SHALL be held stable while out_tvalid=1 and out_tready=0.
REQ-022 pkt_count SHALL increment by 1 on each output handshake with tlast=1, wrapping 0xFFFF->0x0000.
REQ-023 A beat with tkeep=0 SHALL be packed like any other beat, with no special handling.

Reset
REQ-024 On rst: out_tvalid=0, all out payload=0, lane=0, state=ACC, pkt_count=0; in_tready SHALL be 0 while rst=1.
REQ-025 Reset mid-word SHALL discard the partial word; the first beat after release SHALL land in lane 0.

Configuration
REQ-026 Macro AXI4S_UPSIZER_ID_FLUSH_EN defined: REQ-020 is active, so a tid or tdest mismatch against lane 0 flushes a partial word.
REQ-027 Macro undefined: no flush; mismatching beats pack normally, and their tid/tdest are ignored.

Structure
REQ-028 Types data_t1_t, data_t2_t, tid_t1_t/tid_t2_t, tdest_t1_t/tdest_t2_t, tuser_t1_t/tuser_t2_t, and RATIO SHALL live in the shared axi4sDemo package.
REQ-029 One sub-module, axi4s_upsizer_pack, SHALL hold the lane counter and the lane-write/clear datapath; the top SHALL hold the FSM, the handshake, and pkt_count.

Verification
REQ-030 Bench SHALL drive 4 beats with tdata 0x11..,0x22..,0x33..,0x44.., tkeep=0xFF, tlast on beat 4; required output: one word with lanes 0x11..0x44, tkeep=0xFFFFFFFF, tlast=1, and pkt_count=1.
REQ-031 Bench SHALL drive 2 beats with tlast on beat 2; required output: lanes 2-3 zero, tkeep=0x0000FFFF, tuser[15:8]=0.
REQ-032 Bench SHALL stream 8 beats back-to-back with out_tready=1; required: in_tready stays 1 throughout, and 2 words are output on cycles 5 and 9.
REQ-033 Bench SHALL hold out_tready=0 for 3 cycles while a word is in HOLD; required: in_tready=0 and output stable, then release yields exactly one handshake.
REQ-034 With AXI4S_UPSIZER_ID_FLUSH_EN, bench SHALL send beat tid=1, then beat tid=2; required: a partial word with tid=1 and tkeep=0x000000FF, followed by the tid=2 beat in lane 0.
REQ-035 Bench SHALL assert rst after 2 beats of a word; required: no output, then a fresh 4-beat word packs starting at lane 0 with pkt_count=0 before its tlast.
